// File: rtl/instr_sequencer_pkg.sv
// instr_sequencer_pkg: state/cause encodings and ISA decode
// helpers shared by the sequencer and the instruction decoder.
package instr_sequencer_pkg;

  localparam int unsigned ISA_W = 16;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC  = 2'b01,
    ST_HALT  = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    HC_NONE = 2'b00,
    HC_STP  = 2'b01,
    HC_OVF  = 2'b10
  } cause_e;

  // Opcode lives in isa[15:11], condition code in isa[5:2].
  typedef enum logic [4:0] {
    OP_NOP   = 5'h00,
    OP_LDI   = 5'h01,
    OP_AIM   = 5'h02,
    OP_SIM   = 5'h03,
    OP_LOAD  = 5'h04,
    OP_STORE = 5'h05,
    OP_PUSH  = 5'h06,
    OP_POP   = 5'h07,
    OP_ADD   = 5'h08,
    OP_SUB   = 5'h09,
    OP_AND   = 5'h0a,
    OP_OR    = 5'h0b,
    OP_XOR   = 5'h0c,
    OP_SHL   = 5'h0d,
    OP_SHR   = 5'h0e,
    OP_MOV   = 5'h0f,
    OP_MUL   = 5'h10,
    OP_MLS   = 5'h11,
    OP_JMR   = 5'h12,
    OP_JMD   = 5'h13,
    OP_CALL  = 5'h14,
    OP_CAR   = 5'h15,
    OP_RTN   = 5'h16,
    OP_STP   = 5'h17
  } op_e;

  localparam logic [3:0] COND_ALWAYS  = 4'b0110;
  localparam logic [3:0] COND_INVALID = 4'b1110;

  function automatic logic [4:0] op_field(
    input logic [ISA_W-1:0] isa
  );
    return isa[15:11];
  endfunction

  function automatic logic [3:0] cond_field(
    input logic [ISA_W-1:0] isa
  );
    return isa[5:2];
  endfunction

  function automatic int unsigned cycles(
    input logic [4:0]  op,
    input int unsigned mul_lat
  );
    case (op)
      OP_LDI, OP_AIM, OP_SIM,
      OP_LOAD, OP_POP, OP_RTN: return 2;
      OP_MUL, OP_MLS:          return 1 + mul_lat;
      default:                 return 1;
    endcase
  endfunction

  function automatic logic is_mem(input logic [4:0] op);
    case (op)
      OP_LOAD, OP_STORE, OP_PUSH, OP_POP,
      OP_CALL, OP_CAR, OP_RTN: return 1'b1;
      default:                 return 1'b0;
    endcase
  endfunction

  function automatic logic is_jump(input logic [4:0] op);
    case (op)
      OP_JMR, OP_JMD, OP_CALL,
      OP_CAR, OP_RTN: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic logic is_stp(input logic [4:0] op);
    return op == OP_STP;
  endfunction

endpackage

// File: rtl/instr_sequencer_cond_eval.sv
// cond_eval: 4-bit condition code against status flags.
// Low 3 bits pick a flag, MSB inverts it; 0110/1110 always pass.
module cond_eval
  import instr_sequencer_pkg::*;
#(
  parameter int STATUS_W = 8
) (
  input  logic [3:0]          code_i,
  input  logic [STATUS_W-1:0] status_i,
  output logic                pass_o
);

  logic [7:0] flags;

  assign flags = status_i[7:0];

  always_comb begin
    pass_o = flags[code_i[2:0]] ^ code_i[3];
    if (code_i == COND_ALWAYS || code_i == COND_INVALID)
      pass_o = 1'b1;
  end

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch / variable-length exec / halt sequencer
// owning the IR, latched condition and retired-instruction count.
module instr_sequencer
  import instr_sequencer_pkg::*;
#(
  parameter int INSTR_W  = 16,
  parameter int STATUS_W = 8,
  parameter int MUL_LAT  = 2,
  parameter int IDX_W    = 3,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [INSTR_W-1:0]  instr,
  input  logic                instr_valid,
  input  logic                mem_ready,
  input  logic [STATUS_W-1:0] status_reg,
  input  logic                stack_overflow,
  input  logic                run,
  output logic [INSTR_W-1:0]  ir,
  output logic [1:0]          state_o,
  output logic [IDX_W-1:0]    exec_idx,
  output logic                exec_first,
  output logic                exec_last,
  output logic                cond_pass,
  output logic                ir_load,
  output logic                pc_cnt_en,
  output logic                pc_sload,
  output logic                stall,
  output logic                retire,
  output logic                halted,
  output logic [1:0]          halt_cause,
  output logic [CNT_W-1:0]    retired_count
);

  if (STATUS_W < 8 || INSTR_W < 16 ||
      MUL_LAT < 1 || MUL_LAT > 6 ||
      (1 << IDX_W) <= 1 + MUL_LAT) begin : g_bad_params
    $error("instr_sequencer: illegal parameters");
  end

  state_e               state_q, state_d;
  cause_e               cause_q, cause_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     n_q, n_d;
  logic                 cond_q, cond_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [ISA_W-1:0]     isa_in, isa_q;
  logic [4:0]           op_in, op_q;
  logic                 fetch_pass;
  logic                 in_exec;
  logic                 stall_c;
  logic                 last_c;
  logic                 ovf_c;

  assign isa_in = instr[INSTR_W-1 -: ISA_W];
  assign isa_q  = ir_q[INSTR_W-1 -: ISA_W];
  assign op_in  = op_field(isa_in);
  assign op_q   = op_field(isa_q);

  cond_eval #(
    .STATUS_W (STATUS_W)
  ) u_cond (
    .code_i   (cond_field(isa_in)),
    .status_i (status_reg),
    .pass_o   (fetch_pass)
  );

  assign in_exec = state_q == ST_EXEC;
  assign stall_c = in_exec && is_mem(op_q) &&
                   idx_q == '0 && !mem_ready;
  assign last_c  = in_exec && !stall_c &&
                   idx_q == n_q - 1'b1;
  assign ovf_c   = in_exec && stack_overflow;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cause_q <= HC_NONE;
      ir_q    <= '0;
      idx_q   <= '0;
      n_q     <= IDX_W'(1);
      cond_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      ir_q    <= ir_d;
      idx_q   <= idx_d;
      n_q     <= n_d;
      cond_q  <= cond_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ir_d    = ir_q;
    idx_d   = idx_q;
    n_d     = n_q;
    cond_d  = cond_q;
    case (state_q)
      ST_FETCH: begin
        if (instr_valid) begin
          ir_d    = instr;
          cond_d  = fetch_pass;
          n_d     = IDX_W'(cycles(op_in, MUL_LAT));
          idx_d   = '0;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Overflow aborts the instruction and beats a retiring stp.
        if (ovf_c) begin
          idx_d   = '0;
          state_d = ST_HALT;
          cause_d = HC_OVF;
        end else if (last_c) begin
          idx_d = '0;
          if (is_stp(op_q) && cond_q) begin
            state_d = ST_HALT;
            cause_d = HC_STP;
          end else begin
            state_d = ST_FETCH;
          end
        end else if (!stall_c) begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_HALT: begin
        if (run) begin
          state_d = ST_FETCH;
          cause_d = HC_NONE;
        end
      end
      default: state_d = ST_FETCH;
    endcase
  end

  always_comb begin
    ir_load   = 1'b0;
    pc_cnt_en = 1'b0;
    pc_sload  = 1'b0;
    stall     = 1'b0;
    retire    = 1'b0;
    exec_last = 1'b0;
    halted    = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_load   = instr_valid;
        pc_cnt_en = instr_valid;
      end
      ST_EXEC: begin
        stall = stall_c;
        if (last_c && !ovf_c) begin
          exec_last = 1'b1;
          retire    = 1'b1;
          pc_sload  = is_jump(op_q) && cond_q;
        end
      end
      ST_HALT: halted = 1'b1;
      default: ;
    endcase
  end

  assign cnt_d = (retire && cnt_q != '1) ?
                 cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign ir            = ir_q;
  assign state_o       = state_q;
  assign exec_idx      = idx_q;
  assign exec_first    = in_exec && idx_q == '0;
  assign cond_pass     = cond_q;
  assign halt_cause    = cause_q;
  assign retired_count = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed cycle vectors plus a few
// hand-written multi-cycle sequences for instr_sequencer.
module tb_instr_sequencer;

  localparam int CW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        mem_ready;
  logic [7:0]  status_reg;
  logic        stack_overflow;
  logic        run;
  logic [15:0] ir;
  logic [1:0]  state_o;
  logic [2:0]  exec_idx;
  logic        exec_first;
  logic        exec_last;
  logic        cond_pass;
  logic        ir_load;
  logic        pc_cnt_en;
  logic        pc_sload;
  logic        stall;
  logic        retire;
  logic        halted;
  logic [1:0]  halt_cause;
  logic [CW-1:0] retired_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_sequencer #(
    .INSTR_W  (16),
    .STATUS_W (8),
    .MUL_LAT  (2),
    .IDX_W    (3),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr          (instr),
    .instr_valid    (instr_valid),
    .mem_ready      (mem_ready),
    .status_reg     (status_reg),
    .stack_overflow (stack_overflow),
    .run            (run),
    .ir             (ir),
    .state_o        (state_o),
    .exec_idx       (exec_idx),
    .exec_first     (exec_first),
    .exec_last      (exec_last),
    .cond_pass      (cond_pass),
    .ir_load        (ir_load),
    .pc_cnt_en      (pc_cnt_en),
    .pc_sload       (pc_sload),
    .stall          (stall),
    .retire         (retire),
    .halted         (halted),
    .halt_cause     (halt_cause),
    .retired_count  (retired_count)
  );

  // flags: {ir_load,pc_cnt_en,pc_sload,stall,retire,exec_last,halted}
  localparam logic [6:0] NO = 7'b0000000;
  localparam logic [6:0] LC = 7'b1100000;
  localparam logic [6:0] RT = 7'b0000110;
  localparam logic [6:0] RJ = 7'b0010110;
  localparam logic [6:0] SL = 7'b0001000;
  localparam logic [6:0] HL = 7'b0000001;
  localparam logic [1:0] FE = 2'b00;
  localparam logic [1:0] EX = 2'b01;
  localparam logic [1:0] HA = 2'b10;

  localparam logic [15:0] ADD  = 16'h4018;
  localparam logic [15:0] MUL  = 16'h8018;
  localparam logic [15:0] LD   = 16'h2018;
  localparam logic [15:0] ST   = 16'h2818;
  localparam logic [15:0] JMDZ = 16'h9800;
  localparam logic [15:0] JMNZ = 16'h9820;
  localparam logic [15:0] STP  = 16'hb818;
  localparam logic [15:0] STPZ = 16'hb800;

  typedef struct {
    string       name;
    logic        rst;
    logic [15:0] ins;
    logic        iv;
    logic        mr;
    logic [7:0]  st;
    logic        ovf;
    logic        rn;
    logic [1:0]  e_state;
    logic [2:0]  e_idx;
    logic [6:0]  e_flags;
    logic [1:0]  e_cause;
    logic [CW-1:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input string n, input logic r, input logic [15:0] i,
    input logic v, input logic m, input logic [7:0] s,
    input logic o, input logic u, input logic [1:0] es,
    input logic [2:0] ei, input logic [6:0] ef,
    input logic [1:0] ec, input logic [CW-1:0] en
  );
    vec_t t;
    t.name = n; t.rst = r; t.ins = i; t.iv = v;
    t.mr = m; t.st = s; t.ovf = o; t.rn = u;
    t.e_state = es; t.e_idx = ei; t.e_flags = ef;
    t.e_cause = ec; t.e_cnt = en;
    return t;
  endfunction

  task automatic drive(
    input logic r, input logic [15:0] i, input logic v,
    input logic m, input logic [7:0] s, input logic o,
    input logic u
  );
    @(posedge clk);
    #1;
    reset = r; instr = i; instr_valid = v;
    mem_ready = m; status_reg = s;
    stack_overflow = o; run = u;
    @(negedge clk);
  endtask

  task automatic check(
    input string n, input logic [31:0] got,
    input logic [31:0] want
  );
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", n, got, want);
    end
  endtask

  function automatic logic [17:0] obs();
    return {state_o, exec_idx,
            ir_load, pc_cnt_en, pc_sload, stall,
            retire, exec_last, halted,
            halt_cause, retired_count};
  endfunction

  initial begin
    vq.push_back(mk("reset",        1, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 0));
    vq.push_back(mk("add_fetch",    0, ADD,   1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 0));
    vq.push_back(mk("add_exec",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, RT, 0, 0));
    vq.push_back(mk("add_done",     0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 1));
    vq.push_back(mk("mul_fetch",    0, MUL,   1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 1));
    vq.push_back(mk("mul_idx0",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, NO, 0, 1));
    vq.push_back(mk("mul_idx1",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 1, NO, 0, 1));
    vq.push_back(mk("mul_idx2",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 2, RT, 0, 1));
    vq.push_back(mk("mul_done",     0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 2));
    vq.push_back(mk("ld_fetch",     0, LD,    1, 0, 8'h00, 0, 0, FE, 0, LC, 0, 2));
    vq.push_back(mk("ld_stall0",    0, 16'h0, 0, 0, 8'h00, 0, 0, EX, 0, SL, 0, 2));
    vq.push_back(mk("ld_stall1",    0, 16'h0, 0, 0, 8'h00, 0, 0, EX, 0, SL, 0, 2));
    vq.push_back(mk("ld_stall2",    0, 16'h0, 0, 0, 8'h00, 0, 0, EX, 0, SL, 0, 2));
    vq.push_back(mk("ld_ready",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, NO, 0, 2));
    vq.push_back(mk("ld_last",      0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 1, RT, 0, 2));
    vq.push_back(mk("ld_done",      0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 3));
    vq.push_back(mk("jmd_t_fetch",  0, JMDZ,  1, 1, 8'h01, 0, 0, FE, 0, LC, 0, 3));
    vq.push_back(mk("jmd_t_exec",   0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, RJ, 0, 3));
    vq.push_back(mk("jmd_t_done",   0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 4));
    vq.push_back(mk("jmd_n_fetch",  0, JMDZ,  1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 4));
    vq.push_back(mk("jmd_n_exec",   0, 16'h0, 0, 1, 8'h01, 0, 0, EX, 0, RT, 0, 4));
    vq.push_back(mk("iv_low",       0, ADD,   0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 5));
    vq.push_back(mk("jnz_fetch",    0, JMNZ,  1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 5));
    vq.push_back(mk("jnz_exec",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, RJ, 0, 5));
    vq.push_back(mk("jnz_done",     0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 6));
    vq.push_back(mk("stp_fetch",    0, STP,   1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 6));
    vq.push_back(mk("stp_exec",     0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, RT, 0, 6));
    vq.push_back(mk("halt_ovf_ign", 0, 16'h0, 0, 1, 8'h00, 1, 0, HA, 0, HL, 1, 7));
    vq.push_back(mk("halt_iv_ign",  0, ADD,   1, 1, 8'h00, 0, 0, HA, 0, HL, 1, 7));
    vq.push_back(mk("halt_run",     0, 16'h0, 0, 1, 8'h00, 0, 1, HA, 0, HL, 1, 7));
    vq.push_back(mk("run_fetch",    0, 16'h0, 0, 1, 8'h00, 0, 1, FE, 0, NO, 0, 7));
    vq.push_back(mk("ovstp_fetch",  0, STP,   1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 7));
    vq.push_back(mk("ovstp_exec",   0, 16'h0, 0, 1, 8'h00, 1, 0, EX, 0, NO, 0, 7));
    vq.push_back(mk("ovf_halt",     0, 16'h0, 0, 1, 8'h00, 0, 1, HA, 0, HL, 2, 7));
    vq.push_back(mk("ovf_fe_ign",   0, 16'h0, 0, 1, 8'h00, 1, 0, FE, 0, NO, 0, 7));
    vq.push_back(mk("fetch_idle",   0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 7));
    vq.push_back(mk("rmul_fetch",   0, MUL,   1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 7));
    vq.push_back(mk("rmul_idx0",    0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, NO, 0, 7));
    vq.push_back(mk("rmul_rst",     1, 16'h0, 0, 1, 8'h00, 0, 0, EX, 1, NO, 0, 7));
    vq.push_back(mk("rmul_after",   0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 0));
    vq.push_back(mk("rmul_idle",    0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 0));
    vq.push_back(mk("stpn_fetch",   0, STPZ,  1, 1, 8'h00, 0, 0, FE, 0, LC, 0, 0));
    vq.push_back(mk("stpn_exec",    0, 16'h0, 0, 1, 8'h00, 0, 0, EX, 0, RT, 0, 0));
    vq.push_back(mk("stpn_done",    0, 16'h0, 0, 1, 8'h00, 0, 0, FE, 0, NO, 0, 1));

    reset = 1'b1; instr = '0; instr_valid = 1'b0;
    mem_ready = 1'b1; status_reg = '0;
    stack_overflow = 1'b0; run = 1'b0;
    repeat (2) @(posedge clk);

    foreach (vq[k]) begin
      drive(vq[k].rst, vq[k].ins, vq[k].iv, vq[k].mr,
            vq[k].st, vq[k].ovf, vq[k].rn);
      check(vq[k].name, 32'(obs()),
            32'({vq[k].e_state, vq[k].e_idx, vq[k].e_flags,
                 vq[k].e_cause, vq[k].e_cnt}));
    end

    // IR / latched condition / exec_first visibility.
    drive(0, JMDZ, 1, 1, 8'h01, 0, 0);
    drive(0, 16'h0, 0, 1, 8'h00, 0, 0);
    check("ir_cond_first", 32'({ir, cond_pass, exec_first}),
          32'({JMDZ, 1'b1, 1'b1}));
    drive(0, 16'h0, 0, 1, 8'h00, 0, 0);
    check("ir_hold", 32'({ir, exec_first}),
          32'({JMDZ, 1'b0}));

    // Store stalls two cycles, then retires; bounded wait.
    begin
      int stalls = 0;
      bit seen = 0;
      drive(0, ST, 1, 0, 8'h00, 0, 0);
      for (int c = 0; c < 12 && !seen; c++) begin
        drive(0, 16'h0, 0, (c >= 2), 8'h00, 0, 0);
        if (stall) stalls++;
        if (retire) seen = 1;
      end
      check("store_retire", 32'(seen), 32'd1);
      check("store_stalls", 32'(stalls), 32'd2);
      drive(0, 16'h0, 0, 1, 8'h00, 0, 0);
    end

    // Counter saturation: count is 3 here, run 14 more adds.
    for (int k = 0; k < 14; k++) begin
      drive(0, ADD, 1, 1, 8'h00, 0, 0);
      if (k == 12)
        check("cnt_15", 32'(retired_count), 32'd15);
      drive(0, 16'h0, 0, 1, 8'h00, 0, 0);
      if (k == 13)
        check("sat_retire", 32'(retire), 32'd1);
    end
    drive(0, 16'h0, 0, 1, 8'h00, 0, 0);
    check("cnt_saturate", 32'(retired_count), 32'd15);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
